// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO family: defaults, width helper
// and parameter-legality predicates used at elaboration time.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 1) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit depth_ok(input int depth);
    return is_pow2(depth) && (depth >= 4);
  endfunction

  function automatic bit af_level_ok(input int depth, input int af_level);
    return (af_level >= 1) && (af_level <= depth - 1);
  endfunction

  function automatic bit ae_level_ok(input int depth, input int ae_level);
    return (ae_level >= 0) && (ae_level <= depth - 2);
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// DEPTH x DATA_W simple dual-port RAM: synchronous write port, registered
// read port. Only the read register is reset; the array is not.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM macros; the empty guard
  // upstream ensures unwritten locations are never read.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments throughout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: wrap-bit pointers, occupancy/flag decode
// and registered overflow/underflow pulses around a dual-port RAM.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int ADDR_W  = clog2(DEPTH),
  localparam int CNT_W   = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH=%0d must be a power of two >= 4", DEPTH);
  end
  if (!af_level_ok(DEPTH, AF_LEVEL)) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL=%0d must be in 1..DEPTH-1", AF_LEVEL);
  end
  if (!ae_level_ok(DEPTH, AE_LEVEL)) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL=%0d must be in 0..DEPTH-2", AE_LEVEL);
  end

  localparam logic [CNT_W-1:0] AF_CNT  = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT  = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

  logic [CNT_W-1:0] wptr;
  logic [CNT_W-1:0] rptr;
  logic             wr_accept;
  logic             rd_accept;

  // Flags decode only the registered pointers, never the request strobes.
  assign count        = wptr - rptr;
  assign empty        = (wptr == rptr);
  assign full         = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                        (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // Accepts use the pre-edge flags; clear overrides both requests.
  assign wr_accept = wr_en && !full  && !clear;
  assign rd_accept = rd_en && !empty && !clear;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wptr      <= '0;
      rptr      <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_accept) begin
        rptr <= rptr + PTR_ONE;
      end
      rd_valid  <= rd_accept;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_accept),
    .wr_addr (wptr[ADDR_W-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_accept),
    .rd_addr (rptr[ADDR_W-1:0]),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: default 16x8 instance plus a 4x32
// instance with tight thresholds, all expectations hand-derived.
module tb_sync_fifo_param;

  logic clock;

  // Instance A: defaults (DATA_W=8, DEPTH=16, AF=14, AE=2)
  logic       reset_a, clear_a, wr_en_a, rd_en_a;
  logic [7:0] din_a, dout_a;
  logic       rd_valid_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [4:0] count_a;

  // Instance B: DATA_W=32, DEPTH=4, AF=3, AE=1
  logic        reset_b, clear_b, wr_en_b, rd_en_b;
  logic [31:0] din_b, dout_b;
  logic        rd_valid_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [2:0]  count_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  logic [7:0] last_rd;

  sync_fifo_param dut_a (
    .clock(clock), .reset(reset_a), .clear(clear_a),
    .wr_en(wr_en_a), .data_in(din_a), .rd_en(rd_en_a),
    .data_out(dout_a), .rd_valid(rd_valid_a), .full(full_a), .empty(empty_a),
    .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  sync_fifo_param #(.DATA_W(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_b (
    .clock(clock), .reset(reset_b), .clear(clear_b),
    .wr_en(wr_en_b), .data_in(din_b), .rd_en(rd_en_b),
    .data_out(dout_b), .rd_valid(rd_valid_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_a = 1'b0; clear_a = 1'b0; wr_en_a = 1'b0; rd_en_a = 1'b0; din_a = '0;
    reset_b = 1'b0; clear_b = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0; din_b = '0;

    // Reset state
    #12;
    check("a_rst_count", count_a, 0);
    check("a_rst_empty", empty_a, 1);
    check("a_rst_full", full_a, 0);
    check("a_rst_ae", ae_a, 1);
    check("a_rst_af", af_a, 0);
    check("a_rst_rdv", rd_valid_a, 0);
    check("a_rst_dout", dout_a, 0);
    check("a_rst_ovf", ovf_a, 0);
    check("a_rst_unf", unf_a, 0);
    check("b_rst_count", count_b, 0);
    check("b_rst_empty", empty_b, 1);
    check("b_rst_ae", ae_b, 1);
    check("b_rst_af", af_b, 0);
    tick();
    reset_a = 1'b1;
    reset_b = 1'b1;
    tick();

    // ---------------- Instance A: fill to full ----------------
    for (int i = 0; i < 16; i++) begin
      wr_en_a = 1'b1; din_a = 8'(i);
      tick();
      check($sformatf("a_fill%0d_count", i), count_a, i + 1);
      check($sformatf("a_fill%0d_af", i), af_a, (i + 1) >= 14);
      check($sformatf("a_fill%0d_ae", i), ae_a, (i + 1) <= 2);
      check($sformatf("a_fill%0d_full", i), full_a, i == 15);
      check($sformatf("a_fill%0d_empty", i), empty_a, 0);
    end
    din_a = 8'hFF;
    tick();
    check("a_ovf_pulse", ovf_a, 1);
    check("a_ovf_count", count_a, 16);
    wr_en_a = 1'b0;
    tick();
    check("a_ovf_clear", ovf_a, 0);
    check("a_ovf_count2", count_a, 16);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      rd_en_a = 1'b1;
      tick();
      check($sformatf("a_drain%0d_rdv", i), rd_valid_a, 1);
      check($sformatf("a_drain%0d_data", i), dout_a, i);
      check($sformatf("a_drain%0d_count", i), count_a, 15 - i);
      check($sformatf("a_drain%0d_af", i), af_a, (15 - i) >= 14);
      check($sformatf("a_drain%0d_ae", i), ae_a, (15 - i) <= 2);
      check($sformatf("a_drain%0d_empty", i), empty_a, i == 15);
    end
    tick();
    check("a_unf_pulse", unf_a, 1);
    check("a_unf_rdv", rd_valid_a, 0);
    check("a_unf_dout_hold", dout_a, 8'h0F);
    check("a_unf_count", count_a, 0);
    rd_en_a = 1'b0;
    tick();
    check("a_unf_clear", unf_a, 0);

    // ---------------- Instance A: wrap-around ----------------
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    check("a_clr_wptr", dut_a.wptr, 0);
    check("a_clr_count", count_a, 0);
    for (int i = 0; i < 10; i++) begin
      wr_en_a = 1'b1; din_a = 8'(8'h20 + i);
      tick();
    end
    wr_en_a = 1'b0;
    check("a_wrap_count10", count_a, 10);
    for (int i = 0; i < 10; i++) begin
      rd_en_a = 1'b1;
      tick();
      check($sformatf("a_wrap1_data%0d", i), dout_a, 8'h20 + i);
    end
    rd_en_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en_a = 1'b1; din_a = 8'(8'h40 + i);
      tick();
      check($sformatf("a_wrap2_full%0d", i), full_a, i == 15);
      check($sformatf("a_wrap2_count%0d", i), count_a, i + 1);
    end
    check("a_wrap_wptr", dut_a.wptr, 26);
    check("a_wrap_rptr", dut_a.rptr, 10);
    // Full: write rejected even with a same-cycle accepted read
    rd_en_a = 1'b1; din_a = 8'hFE;
    tick();
    check("a_fullrw_ovf", ovf_a, 1);
    check("a_fullrw_rdv", rd_valid_a, 1);
    check("a_fullrw_data", dout_a, 8'h40);
    check("a_fullrw_count", count_a, 15);
    wr_en_a = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("a_wrap2_data%0d", i), dout_a, 8'h41 + i);
    end
    rd_en_a = 1'b0;
    check("a_wrap_empty", empty_a, 1);

    // ---------------- Instance A: simultaneous traffic ----------------
    wr_en_a = 1'b1; rd_en_a = 1'b1; din_a = 8'h99;
    tick();
    check("a_sim0_count", count_a, 1);
    check("a_sim0_unf", unf_a, 1);
    check("a_sim0_rdv", rd_valid_a, 0);
    exp_q.push_back(8'h99);
    rd_en_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_a = 8'(8'h60 + i);
      tick();
      exp_q.push_back(din_a);
    end
    check("a_sim5_count", count_a, 5);
    rd_en_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din_a = 8'(8'h70 + i);
      tick();
      exp_q.push_back(din_a);
      exp_byte = exp_q.pop_front();
      check($sformatf("a_sim%0d_data", i), dout_a, exp_byte);
      check($sformatf("a_sim%0d_rdv", i), rd_valid_a, 1);
      check($sformatf("a_sim%0d_count", i), count_a, 5);
    end
    last_rd = exp_byte;
    rd_en_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din_a = 8'(8'hC0 + i);
      tick();
    end
    check("a_pre_clear_count", count_a, 7);

    // ---------------- Instance A: clear beats write ----------------
    clear_a = 1'b1; din_a = 8'hEE;
    tick();
    clear_a = 1'b0; wr_en_a = 1'b0;
    exp_q.delete();
    check("a_clear_count", count_a, 0);
    check("a_clear_empty", empty_a, 1);
    check("a_clear_rdv", rd_valid_a, 0);
    check("a_clear_dout_hold", dout_a, last_rd);
    wr_en_a = 1'b1; din_a = 8'h11;
    tick();
    wr_en_a = 1'b0;
    check("a_postclr_count", count_a, 1);
    rd_en_a = 1'b1;
    tick();
    rd_en_a = 1'b0;
    check("a_postclr_data", dout_a, 8'h11);

    // ---------------- Instance A: async reset mid-burst ----------------
    for (int i = 0; i < 9; i++) begin
      wr_en_a = 1'b1; din_a = 8'(8'hB0 + i);
      tick();
    end
    rd_en_a = 1'b1; din_a = 8'hB9;
    tick();
    check("a_burst_count", count_a, 9);
    check("a_burst_rdv", rd_valid_a, 1);
    check("a_burst_data", dout_a, 8'hB0);
    wr_en_a = 1'b0; rd_en_a = 1'b0;
    #3;
    reset_a = 1'b0;
    #1;
    check("a_async_count", count_a, 0);
    check("a_async_empty", empty_a, 1);
    check("a_async_full", full_a, 0);
    check("a_async_rdv", rd_valid_a, 0);
    check("a_async_dout", dout_a, 0);
    check("a_async_ae", ae_a, 1);
    check("a_async_af", af_a, 0);
    tick();
    tick();
    reset_a = 1'b1;
    tick();
    wr_en_a = 1'b1; din_a = 8'hA5;
    tick();
    wr_en_a = 1'b0;
    check("a_rel_count", count_a, 1);
    check("a_rel_addr0", dut_a.u_ram.mem[0], 8'hA5);
    rd_en_a = 1'b1;
    tick();
    rd_en_a = 1'b0;
    check("a_rel_data", dout_a, 8'hA5);
    check("a_rel_rdv", rd_valid_a, 1);
    check("a_rel_empty", empty_a, 1);

    // ---------------- Instance B: DEPTH=4, DATA_W=32 ----------------
    for (int i = 0; i < 4; i++) begin
      wr_en_b = 1'b1; din_b = 32'hCAFE_0000 + i;
      tick();
      check($sformatf("b_fill%0d_count", i), count_b, i + 1);
      check($sformatf("b_fill%0d_af", i), af_b, (i + 1) >= 3);
      check($sformatf("b_fill%0d_ae", i), ae_b, (i + 1) <= 1);
      check($sformatf("b_fill%0d_full", i), full_b, i == 3);
    end
    din_b = 32'hDEAD_BEEF;
    tick();
    wr_en_b = 1'b0;
    check("b_ovf_pulse", ovf_b, 1);
    check("b_ovf_count", count_b, 4);
    tick();
    check("b_ovf_clear", ovf_b, 0);
    for (int i = 0; i < 4; i++) begin
      rd_en_b = 1'b1;
      tick();
      check($sformatf("b_drain%0d_data", i), dout_b, 32'hCAFE_0000 + i);
      check($sformatf("b_drain%0d_rdv", i), rd_valid_b, 1);
      check($sformatf("b_drain%0d_count", i), count_b, 3 - i);
      check($sformatf("b_drain%0d_af", i), af_b, (3 - i) >= 3);
      check($sformatf("b_drain%0d_ae", i), ae_b, (3 - i) <= 1);
      check($sformatf("b_drain%0d_empty", i), empty_b, i == 3);
    end
    tick();
    rd_en_b = 1'b0;
    check("b_unf_pulse", unf_b, 1);
    check("b_unf_rdv", rd_valid_b, 0);
    tick();
    check("b_unf_clear", unf_b, 0);

    // Wrap across the 4-entry array
    for (int i = 0; i < 3; i++) begin
      wr_en_b = 1'b1; din_b = 32'h1000_0000 + i;
      tick();
    end
    wr_en_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_en_b = 1'b1;
      tick();
      check($sformatf("b_wrap1_data%0d", i), dout_b, 32'h1000_0000 + i);
    end
    rd_en_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en_b = 1'b1; din_b = 32'h2000_0000 + i;
      tick();
      check($sformatf("b_wrap2_full%0d", i), full_b, i == 3);
    end
    wr_en_b = 1'b0;
    check("b_wrap2_count", count_b, 4);
    for (int i = 0; i < 4; i++) begin
      rd_en_b = 1'b1;
      tick();
      check($sformatf("b_wrap2_data%0d", i), dout_b, 32'h2000_0000 + i);
    end
    rd_en_b = 1'b0;
    check("b_wrap2_empty", empty_b, 1);

    // Simultaneous requests while empty
    wr_en_b = 1'b1; rd_en_b = 1'b1; din_b = 32'h5555_AAAA;
    tick();
    wr_en_b = 1'b0;
    check("b_sim0_count", count_b, 1);
    check("b_sim0_unf", unf_b, 1);
    check("b_sim0_rdv", rd_valid_b, 0);
    tick();
    rd_en_b = 1'b0;
    check("b_sim0_data", dout_b, 32'h5555_AAAA);
    check("b_sim0_empty", empty_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
